// File: rtl/sram_port_arbiter.sv
// Arbitrates one 1-cycle-latency single-port SRAM between the fetch and data ports.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive data wins.
module sram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req_valid,
    output logic        inst_req_ready,
    input  logic [3:0]  inst_req_wen,
    input  logic [31:0] inst_req_addr,
    input  logic [31:0] inst_req_wdata,
    output logic        inst_rsp_valid,
    input  logic        inst_rsp_ready,
    output logic [31:0] inst_rsp_rdata,

    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic [3:0]  data_req_wen,
    input  logic [31:0] data_req_addr,
    input  logic [31:0] data_req_wdata,
    output logic        data_rsp_valid,
    input  logic        data_rsp_ready,
    output logic [31:0] data_rsp_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STREAK_W = 4;

    logic                gnt_inst_q;
    logic                gnt_data_q;
    logic                held_inst_q;
    logic                held_data_q;
    logic [DATA_W-1:0]   hold_inst_q;
    logic [DATA_W-1:0]   hold_data_q;
    logic [STREAK_W-1:0] streak;

    logic inst_elig;
    logic data_elig;
    logic starved;
    logic grant_inst;
    logic grant_data;

    // Response outputs: bypass SRAM data in the cycle after a grant, else replay the hold register.
    always_comb begin
        inst_rsp_valid = 1'b0;
        data_rsp_valid = 1'b0;
        inst_rsp_rdata = '0;
        data_rsp_rdata = '0;
        if (!reset) begin
            inst_rsp_valid = gnt_inst_q | held_inst_q;
            data_rsp_valid = gnt_data_q | held_data_q;
            inst_rsp_rdata = gnt_inst_q ? sram_rdata : hold_inst_q;
            data_rsp_rdata = gnt_data_q ? sram_rdata : hold_data_q;
        end
    end

    // Grant selection: a port may only issue when its response slot frees up this cycle.
    always_comb begin
        inst_elig  = inst_req_valid & (~inst_rsp_valid | inst_rsp_ready);
        data_elig  = data_req_valid & (~data_rsp_valid | data_rsp_ready);
        starved    = (streak == STREAK_W'(STARVE_LIMIT));
        grant_data = ~reset & data_elig & ~(inst_elig & starved);
        grant_inst = ~reset & inst_elig & ~grant_data;
        inst_req_ready = grant_inst;
        data_req_ready = grant_data;
    end

    // SRAM drive from the granted port; all zero when idle.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_inst) begin
            sram_en    = 1'b1;
            sram_wen   = inst_req_wen;
            sram_addr  = inst_req_addr;
            sram_wdata = inst_req_wdata;
        end else if (grant_data) begin
            sram_en    = 1'b1;
            sram_wen   = data_req_wen;
            sram_addr  = data_req_addr;
            sram_wdata = data_req_wdata;
        end
    end

    // Grant history, response hold state and starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_inst_q  <= 1'b0;
            gnt_data_q  <= 1'b0;
            held_inst_q <= 1'b0;
            held_data_q <= 1'b0;
            hold_inst_q <= '0;
            hold_data_q <= '0;
            streak      <= '0;
        end else begin
            gnt_inst_q  <= grant_inst;
            gnt_data_q  <= grant_data;
            held_inst_q <= inst_rsp_valid & ~inst_rsp_ready;
            held_data_q <= data_rsp_valid & ~data_rsp_ready;
            if (gnt_inst_q) begin
                hold_inst_q <= sram_rdata;
            end
            if (gnt_data_q) begin
                hold_data_q <= sram_rdata;
            end
            if (grant_inst || !inst_req_valid) begin
                streak <= '0;
            end else if (grant_data && !starved) begin
                streak <= streak + STREAK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model of grants, pending responses and memory contents.
module tb_sram_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req_valid, inst_req_ready, inst_rsp_valid, inst_rsp_ready;
    logic [3:0]  inst_req_wen;
    logic [31:0] inst_req_addr, inst_req_wdata, inst_rsp_rdata;
    logic        data_req_valid, data_req_ready, data_rsp_valid, data_rsp_ready;
    logic [3:0]  data_req_wen;
    logic [31:0] data_req_addr, data_req_wdata, data_rsp_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = 32'd0;

    int checks = 0;
    int failures = 0;

    sram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_req_wen(inst_req_wen), .inst_req_addr(inst_req_addr),
        .inst_req_wdata(inst_req_wdata), .inst_rsp_valid(inst_rsp_valid),
        .inst_rsp_ready(inst_rsp_ready), .inst_rsp_rdata(inst_rsp_rdata),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_req_wen(data_req_wen), .data_req_addr(data_req_addr),
        .data_req_wdata(data_req_wdata), .data_rsp_valid(data_rsp_valid),
        .data_rsp_ready(data_rsp_ready), .data_rsp_rdata(data_rsp_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 64)  return 32'hDEADBEEF;
        if (i == 128) return 32'hAAAAAAAA;
        return 32'h1000_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SRAM macro model: synchronous read, byte-enabled write.
    logic [31:0] sram_mem [256];
    bit sram_init = 1'b0;
    always @(posedge clk) begin
        logic [31:0] w;
        if (!sram_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] = init_word(i);
            sram_init = 1'b1;
        end
        if (sram_en) begin
            w = sram_mem[sram_addr[9:2]];
            sram_rdata <= w;
            sram_mem[sram_addr[9:2]] = merge(w, sram_wdata, sram_wen);
        end
    end

    // Reference model: one pending response per port, grant rules, streak count, shadow memory.
    logic [31:0] ref_mem [256];
    bit          ref_init = 1'b0;
    logic        m_pend_i = 1'b0, m_pend_d = 1'b0, m_wr_i = 1'b0, m_wr_d = 1'b0;
    logic [31:0] m_data_i = 32'd0, m_data_d = 32'd0;
    int          m_streak = 0;

    always @(negedge clk) begin
        logic el_i, el_d, g_i, g_d;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_wdata;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
        end
        if (reset) begin
            chk1("rst_inst_req_ready", inst_req_ready, 1'b0);
            chk1("rst_data_req_ready", data_req_ready, 1'b0);
            chk1("rst_inst_rsp_valid", inst_rsp_valid, 1'b0);
            chk1("rst_data_rsp_valid", data_rsp_valid, 1'b0);
            chk32("rst_inst_rdata", inst_rsp_rdata, 32'd0);
            chk32("rst_data_rdata", data_rsp_rdata, 32'd0);
            chk1("rst_sram_en", sram_en, 1'b0);
            chk32("rst_sram_bus", {sram_wen, sram_addr[27:0]} | sram_wdata, 32'd0);
            m_pend_i = 1'b0;
            m_pend_d = 1'b0;
            m_streak = 0;
        end else begin
            chk1("inst_rsp_valid", inst_rsp_valid, m_pend_i);
            chk1("data_rsp_valid", data_rsp_valid, m_pend_d);
            if (m_pend_i && !m_wr_i) chk32("inst_rsp_rdata", inst_rsp_rdata, m_data_i);
            if (m_pend_d && !m_wr_d) chk32("data_rsp_rdata", data_rsp_rdata, m_data_d);
            chk32("streak", 32'(dut.streak), 32'(m_streak));

            el_i = inst_req_valid && (!m_pend_i || inst_rsp_ready);
            el_d = data_req_valid && (!m_pend_d || data_rsp_ready);
            g_i = 1'b0;
            g_d = 1'b0;
            if (el_i && el_d) begin
                if (m_streak == STARVE_LIMIT) g_i = 1'b1;
                else g_d = 1'b1;
            end else if (el_d) g_d = 1'b1;
            else if (el_i) g_i = 1'b1;

            chk1("inst_req_ready", inst_req_ready, g_i);
            chk1("data_req_ready", data_req_ready, g_d);
            e_wen = 4'd0; e_addr = 32'd0; e_wdata = 32'd0;
            if (g_i) begin e_wen = inst_req_wen; e_addr = inst_req_addr; e_wdata = inst_req_wdata; end
            if (g_d) begin e_wen = data_req_wen; e_addr = data_req_addr; e_wdata = data_req_wdata; end
            chk1("sram_en", sram_en, g_i | g_d);
            chk32("sram_wen", 32'(sram_wen), 32'(e_wen));
            chk32("sram_addr", sram_addr, e_addr);
            chk32("sram_wdata", sram_wdata, e_wdata);

            if (m_pend_i && inst_rsp_ready) m_pend_i = 1'b0;
            if (m_pend_d && data_rsp_ready) m_pend_d = 1'b0;
            if (g_i) begin
                m_pend_i = 1'b1; m_wr_i = (e_wen != 4'd0); m_data_i = ref_mem[e_addr[9:2]];
            end
            if (g_d) begin
                m_pend_d = 1'b1; m_wr_d = (e_wen != 4'd0); m_data_d = ref_mem[e_addr[9:2]];
            end
            if (g_i || g_d) ref_mem[e_addr[9:2]] = merge(ref_mem[e_addr[9:2]], e_wdata, e_wen);

            if (g_i || !inst_req_valid) m_streak = 0;
            else if (g_d && m_streak < STARVE_LIMIT) m_streak = m_streak + 1;
        end
    end

    logic [31:0] fetch_exp [3] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002};
    logic [9:0]  cont_seq = 10'b10_0001_0000;  // bit k: inst wins cycle k

    initial begin
        reset = 1'b1;
        inst_req_valid = 1'b0; inst_req_wen = 4'd0; inst_req_addr = 32'd0; inst_req_wdata = 32'd0;
        data_req_valid = 1'b0; data_req_wen = 4'd0; data_req_addr = 32'd0; data_req_wdata = 32'd0;
        inst_rsp_ready = 1'b1; data_rsp_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Idle
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1("idle_sram_en", sram_en, 1'b0);
            chk32("idle_sram_addr", sram_addr, 32'd0);
            chk32("idle_streak", 32'(dut.streak), 32'd0);
            step();
        end

        // Single fetch stream
        for (int c = 0; c < 4; c++) begin
            inst_req_valid = (c < 3);
            inst_req_addr = 32'(4 * c);
            @(negedge clk);
            if (c < 3) chk1("fetch_ready", inst_req_ready, 1'b1);
            if (c > 0) begin
                chk1("fetch_rsp_valid", inst_rsp_valid, 1'b1);
                chk32("fetch_rdata", inst_rsp_rdata, fetch_exp[c-1]);
            end
            step();
        end

        // Contention
        inst_req_valid = 1'b1; inst_req_addr = 32'h10;
        data_req_valid = 1'b1; data_req_addr = 32'h20;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk1("cont_inst_gnt", inst_req_ready, cont_seq[k]);
            chk1("cont_data_gnt", data_req_ready, !cont_seq[k]);
            step();
        end
        @(negedge clk);
        chk32("cont_streak_after_i", 32'(dut.streak), 32'd0);
        step();
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        step();

        // Backpressure on data
        data_req_valid = 1'b1; data_req_addr = 32'h100; data_rsp_ready = 1'b0;
        @(negedge clk);
        chk1("bp_first_gnt", data_req_ready, 1'b1);
        step();
        data_req_addr = 32'h104;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("bp_rsp_valid", data_rsp_valid, 1'b1);
            chk32("bp_rdata", data_rsp_rdata, 32'hDEADBEEF);
            chk1("bp_no_gnt", data_req_ready, 1'b0);
            step();
        end
        data_rsp_ready = 1'b1;
        @(negedge clk);
        chk32("bp_rdata_release", data_rsp_rdata, 32'hDEADBEEF);
        chk1("bp_second_gnt", data_req_ready, 1'b1);
        step();
        data_req_valid = 1'b0;
        @(negedge clk);
        chk32("bp_second_rdata", data_rsp_rdata, 32'h1000_0041);
        step();

        // Write then read
        data_req_valid = 1'b1; data_req_wen = 4'b0011; data_req_addr = 32'h200;
        data_req_wdata = 32'h12345678;
        @(negedge clk);
        chk1("wr_gnt", data_req_ready, 1'b1);
        step();
        data_req_wen = 4'd0;
        @(negedge clk);
        chk1("wr_rsp_valid", data_rsp_valid, 1'b1);
        chk1("rd_gnt", data_req_ready, 1'b1);
        step();
        data_req_valid = 1'b0;
        @(negedge clk);
        chk32("rd_after_wr", data_rsp_rdata, 32'hAAAA5678);
        step();

        // Reset mid-flight
        inst_req_valid = 1'b1; inst_req_addr = 32'h8;
        @(negedge clk);
        chk1("rm_gnt", inst_req_ready, 1'b1);
        step();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk1("rm_rsp_valid", inst_rsp_valid, 1'b0);
            chk1("rm_req_ready", inst_req_ready, 1'b0);
            step();
        end
        reset = 1'b0; inst_req_valid = 1'b0;
        @(negedge clk);
        chk1("rm_after_rsp_valid", inst_rsp_valid, 1'b0);
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            inst_req_valid = ($urandom_range(0, 9) < 7);
            data_req_valid = ($urandom_range(0, 9) < 7);
            inst_req_wen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            data_req_wen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            inst_req_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            data_req_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            inst_req_wdata = $urandom;
            data_req_wdata = $urandom;
            inst_rsp_ready = ($urandom_range(0, 3) != 0);
            data_rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0; inst_req_valid = 1'b0; data_req_valid = 1'b0;
        inst_rsp_ready = 1'b1; data_rsp_ready = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
